// File: rtl/lsp_prev_update_pkg.sv
`default_nettype none
// lsp_prev_update_pkg: shared G.729 LSP constants and history-update FSM states.
// Rev 1.0 - initial release
package lsp_prev_update_pkg;

   localparam int unsigned G729_M     = 10;
   localparam int unsigned G729_MA_NP = 4;
   localparam int unsigned ADDR_W     = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FIN   = 2'd3
   } lsp_state_e;

endpackage
`default_nettype wire

// File: rtl/lsp_prev_update.sv
`default_nettype none
// lsp_prev_update: shifts the MA-predictor history down one row, then stores lsp_ele in row 0.
// Rev 1.0 - initial release
module lsp_prev_update
   import lsp_prev_update_pkg::*;
#(
   parameter int unsigned M     = G729_M,
   parameter int unsigned MA_NP = G729_MA_NP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] lspEleAddr,
   input  logic [10:0] freqPrevAddr,
   output logic        copyStart,
   output logic [10:0] copyXAddr,
   output logic [10:0] copyYAddr,
   output logic [15:0] copyL,
   input  logic        copyDone,
   output logic        busy,
   output logic        done
);

   localparam int unsigned    K_W     = (MA_NP > 1) ? $clog2(MA_NP) : 1;
   localparam logic [10:0]    M_ADDR  = 11'(M);
   localparam logic [10:0]    TOP_OFS = 11'((MA_NP - 1) * M);
   localparam logic [K_W-1:0] K_TOP   = K_W'(MA_NP - 1);
   localparam logic [K_W-1:0] K_ONE   = K_W'(1);

   lsp_state_e     state_q, state_d;
   logic [K_W-1:0] k_q, k_d;
   logic [10:0]    y_q, y_d;
   logic [10:0]    lsp_q, lsp_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         y_q     <= '0;
         lsp_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         y_q     <= y_d;
         lsp_q   <= lsp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      y_d     = y_q;
      lsp_d   = lsp_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               lsp_d   = lspEleAddr;
               k_d     = K_TOP;
               y_d     = freqPrevAddr + TOP_OFS;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            // Row pointer walks downward one row per completed copy.
            if (copyDone) begin
               if (k_q == '0) begin
                  state_d = ST_FIN;
               end else begin
                  k_d     = k_q - K_ONE;
                  y_d     = y_q - M_ADDR;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Addresses derive only from registered state, so they hold through ISSUE and WAIT.
   assign copyStart = (state_q == ST_ISSUE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign copyYAddr = y_q;
   assign copyXAddr = (k_q == '0) ? lsp_q : (y_q - M_ADDR);
   assign copyL     = 16'(M);

endmodule
`default_nettype wire

// File: tb/tb_lsp_prev_update.sv
`default_nettype none
// tb_lsp_prev_update: directed history-update runs against a copy-engine responder,
// a memory image and a reference copy-sequence model.
module tb_lsp_prev_update;

   localparam int M      = 10;
   localparam int MA_NP  = 4;
   localparam int AMOD   = 2048;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [10:0] lspEleAddr = '0;
   logic [10:0] freqPrevAddr = '0;
   logic        copyStart;
   logic [10:0] copyXAddr;
   logic [10:0] copyYAddr;
   logic [15:0] copyL;
   logic        copyDone;
   logic        copyDone_rsp = 1'b0;
   logic        stray_done = 1'b0;
   logic        busy;
   logic        done;

   assign copyDone = copyDone_rsp | stray_done;

   lsp_prev_update #(.M(M), .MA_NP(MA_NP)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .lspEleAddr   (lspEleAddr),
      .freqPrevAddr (freqPrevAddr),
      .copyStart    (copyStart),
      .copyXAddr    (copyXAddr),
      .copyYAddr    (copyYAddr),
      .copyL        (copyL),
      .copyDone     (copyDone),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   typedef struct {int x; int y;} pair_t;
   pair_t exp_q[$];
   pair_t seen_q[$];
   int    mem  [AMOD];
   int    snap [AMOD];

   // Reference order: shift rows top-down, then lsp_ele into row 0.
   task automatic push_expected(input int lsp, input int fp);
      for (int k = MA_NP - 1; k >= 1; k--)
         exp_q.push_back('{(fp + (k - 1) * M) % AMOD, (fp + k * M) % AMOD});
      exp_q.push_back('{lsp % AMOD, fp % AMOD});
   endtask

   // Copy-engine stand-in: moves the data immediately, pulses copyDone lat cycles later.
   int lat = 21;
   int rsp_cnt = 0;
   always @(negedge clk) begin
      copyDone_rsp = 1'b0;
      if (reset) begin
         rsp_cnt = 0;
      end else begin
         if (rsp_cnt != 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) copyDone_rsp = 1'b1;
         end
         if (copyStart) begin
            for (int i = 0; i < int'(copyL); i++)
               mem[(int'(copyYAddr) + i) % AMOD] = mem[(int'(copyXAddr) + i) % AMOD];
            rsp_cnt = lat;
         end
      end
   end

   // Per-cycle compare against the reference sequence.
   int          n_cs = 0;
   int          n_done = 0;
   logic        prev_cs = 1'b0;
   logic        pending = 1'b0;
   logic [10:0] hold_x = '0;
   logic [10:0] hold_y = '0;
   always @(negedge clk) begin
      pair_t e;
      #1;
      if (reset) begin
         pending = 1'b0;
         prev_cs = 1'b0;
      end else begin
         check("copyL", 32'(copyL), M);
         if (copyStart) begin
            check("copyStart_single_cycle", 32'(prev_cs), 0);
            seen_q.push_back('{int'(copyXAddr), int'(copyYAddr)});
            n_cs++;
            check("copy_request_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("copyXAddr", 32'(copyXAddr), e.x);
               check("copyYAddr", 32'(copyYAddr), e.y);
            end
            hold_x  = copyXAddr;
            hold_y  = copyYAddr;
            pending = 1'b1;
         end else if (pending) begin
            check("copyXAddr_hold", 32'(copyXAddr), 32'(hold_x));
            check("copyYAddr_hold", 32'(copyYAddr), 32'(hold_y));
            check("busy_in_wait", 32'(busy), 1);
            if (copyDone) pending = 1'b0;
         end
         if (done) n_done++;
         prev_cs = copyStart;
      end
   end

   task automatic run(input int lsp, input int fp, input int latency,
                      input int restart_at, input int abort_at, output int done_at);
      int cs0;
      int d0;
      bit aborted;
      lat     = latency;
      cs0     = n_cs;
      d0      = n_done;
      done_at = -1;
      aborted = 0;
      seen_q.delete();
      push_expected(lsp, fp);
      @(negedge clk);
      lspEleAddr   = 11'(lsp);
      freqPrevAddr = 11'(fp);
      start        = 1'b1;
      for (int n = 1; n <= 3000 && done_at < 0 && !aborted; n++) begin
         @(negedge clk);
         start = (n == restart_at);
         if (n == 1) check("busy_after_start", 32'(busy), 1);
         if (n == 2) begin
            lspEleAddr   = 11'h7FF;
            freqPrevAddr = 11'h555;
         end
         if (done) done_at = n;
         if (n == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_busy", 32'(busy), 0);
            check("abort_copyStart", 32'(copyStart), 0);
            check("abort_done", 32'(done), 0);
            exp_q.delete();
            repeat (60) @(negedge clk);
            check("abort_no_done", n_done - d0, 0);
            check("abort_copy_count", n_cs - cs0, 2);
            aborted = 1;
         end
      end
      if (!aborted) begin
         check("done_seen", 32'(done_at >= 0), 1);
         @(negedge clk);
         check("done_one_cycle", 32'(done), 0);
         check("idle_after_done", 32'(busy), 0);
         repeat (3) @(negedge clk);
         check("copy_count", n_cs - cs0, MA_NP);
         check("done_count", n_done - d0, 1);
         check("sequence_consumed", exp_q.size(), 0);
      end
   endtask

   int d;
   int nom_x [4] = '{120, 110, 100, 20};
   int nom_y [4] = '{130, 120, 110, 100};

   initial begin
      for (int i = 0; i < AMOD; i++) mem[i] = i * 7 + 3;

      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_copyStart", 32'(copyStart), 0);
      check("reset_copyXAddr", 32'(copyXAddr), 0);
      check("reset_copyYAddr", 32'(copyYAddr), 0);
      check("reset_copyL", 32'(copyL), M);
      reset = 1'b0;
      @(negedge clk);

      // Nominal run: addresses, latency and resulting memory image.
      snap = mem;
      run(20, 100, 21, 0, 0, d);
      check("nominal_done_cycle", d, 89);
      check("nominal_copy_count", seen_q.size(), 4);
      for (int j = 0; j < 4; j++) begin
         check("nominal_x_literal", seen_q[j].x, nom_x[j]);
         check("nominal_y_literal", seen_q[j].y, nom_y[j]);
      end
      for (int i = 0; i < M; i++) begin
         check("mem_row0", mem[100 + i], snap[20 + i]);
         for (int r = 1; r < MA_NP; r++)
            check("mem_row_shift", mem[100 + r * M + i], snap[100 + (r - 1) * M + i]);
      end

      // Wrap-around of the 11-bit address space.
      run(300, 2040, 21, 0, 0, d);
      check("wrap_first_x", seen_q[0].x, 12);
      check("wrap_first_y", seen_q[0].y, 22);
      check("wrap_last_x", seen_q[seen_q.size() - 1].x, 300);
      check("wrap_last_y", seen_q[seen_q.size() - 1].y, 2040);

      // Start re-pulsed during WAIT must be ignored.
      run(20, 100, 21, 5, 0, d);
      check("busy_test_done_cycle", d, 89);

      // Reset during the second WAIT, then a fresh full sequence.
      run(20, 100, 21, 0, 30, d);
      run(20, 100, 21, 0, 0, d);
      check("post_abort_done_cycle", d, 89);

      // Stray copyDone in IDLE, then a slow responder.
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      check("stray_busy", 32'(busy), 0);
      check("stray_copyStart", 32'(copyStart), 0);
      run(40, 500, 50, 0, 0, d);
      check("slow_done_cycle", d, 205);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d errors of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
